// File: rtl/vending_controller.sv
// rtl/vending_controller.sv - coin/credit vending controller FSM with optional per-code stock (VEND_STOCK_EN)
module vending_controller #(
    parameter logic [3:0] PRICE0     = 4'd1,
    parameter logic [3:0] PRICE1     = 4'd2,
    parameter logic [3:0] PRICE2     = 4'd3,
    parameter logic [3:0] PRICE3     = 4'd4,
    parameter logic [2:0] STOCK_INIT = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [3:0] coin_value,
    input  logic       sel_valid,
    input  logic [1:0] sel_code,
    input  logic [2:0] sel_count,
    input  logic       cancel,
    input  logic       dispense_ack,
    output logic       dispense_req,
    output logic [1:0] dispense_code,
    output logic [2:0] dispense_count,
    output logic       change_valid,
    output logic [3:0] change_amount,
    output logic [3:0] credit,
    output logic       coin_reject,
    output logic       error
);
    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

    state_t     state, state_next;
    logic [3:0] credit_next;
    logic [1:0] code_next;
    logic [2:0] count_next;
    logic       coin_reject_next, error_next;
    logic       stock_take, stock_ok, coin_accept, shopping;
    logic [4:0] coin_sum, sel_total, disp_total;

    function automatic logic [4:0] price_total(input logic [1:0] code, input logic [2:0] count);
        logic [3:0] p;
        logic [7:0] prod;
        case (code)
            2'd0:    p = PRICE0;
            2'd1:    p = PRICE1;
            2'd2:    p = PRICE2;
            default: p = PRICE3;
        endcase
        prod = {4'd0, p} * {5'd0, count};
        return prod[4:0];
    endfunction

    assign coin_sum   = {1'b0, credit} + {1'b0, coin_value};
    assign sel_total  = price_total(sel_code, sel_count);
    assign disp_total = price_total(dispense_code, dispense_count);
    assign shopping   = (state == IDLE) || (state == COLLECT);

`ifdef VEND_STOCK_EN
    logic [2:0] stock [4];
    assign stock_ok = (stock[sel_code] >= sel_count);
`else
    assign stock_ok = 1'b1;
`endif

    // Any simultaneous cancel/selection wins over the coin, which is then bounced.
    assign coin_accept = coin_valid && shopping && !cancel && !sel_valid &&
                         (coin_value != 4'd0) && (coin_sum <= 5'd15);

    always_comb begin
        state_next       = state;
        credit_next      = credit;
        code_next        = dispense_code;
        count_next       = dispense_count;
        coin_reject_next = coin_valid && !coin_accept;
        error_next       = 1'b0;
        stock_take       = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (cancel && state == COLLECT) begin
                    state_next = CHANGE;
                end else if (sel_valid) begin
                    if (sel_count != 3'd0 && sel_total <= {1'b0, credit} && stock_ok) begin
                        state_next = DISPENSE;
                        code_next  = sel_code;
                        count_next = sel_count;
                    end else begin
                        error_next = 1'b1;
                    end
                end else if (coin_accept) begin
                    credit_next = coin_sum[3:0];
                    state_next  = COLLECT;
                end
            end
            DISPENSE: begin
                if (dispense_ack) begin
                    credit_next = credit - disp_total[3:0];
                    stock_take  = 1'b1;
                    state_next  = (credit_next != 4'd0) ? CHANGE : IDLE;
                end
            end
            default: begin
                credit_next = 4'd0;
                state_next  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            credit         <= 4'd0;
            dispense_code  <= 2'd0;
            dispense_count <= 3'd0;
            coin_reject    <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= state_next;
            credit         <= credit_next;
            dispense_code  <= code_next;
            dispense_count <= count_next;
            coin_reject    <= coin_reject_next;
            error          <= error_next;
        end
    end

`ifdef VEND_STOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) stock[i] <= STOCK_INIT;
        end else if (stock_take) begin
            stock[dispense_code] <= stock[dispense_code] - dispense_count;
        end
    end
`endif

    assign dispense_req  = (state == DISPENSE);
    assign change_valid  = (state == CHANGE);
    assign change_amount = change_valid ? credit : 4'd0;
endmodule

// File: tb/tb_vending_controller.sv
// tb/tb_vending_controller.sv - directed self-checking bench for vending_controller
module tb_vending_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [3:0] coin_value;
    logic       sel_valid;
    logic [1:0] sel_code;
    logic [2:0] sel_count;
    logic       cancel;
    logic       dispense_ack;
    logic       dispense_req;
    logic [1:0] dispense_code;
    logic [2:0] dispense_count;
    logic       change_valid;
    logic [3:0] change_amount;
    logic [3:0] credit;
    logic       coin_reject;
    logic       error;

    int total = 0;
    int bad   = 0;

    vending_controller dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_code(sel_code), .sel_count(sel_count),
        .cancel(cancel), .dispense_ack(dispense_ack),
        .dispense_req(dispense_req), .dispense_code(dispense_code),
        .dispense_count(dispense_count), .change_valid(change_valid),
        .change_amount(change_amount), .credit(credit),
        .coin_reject(coin_reject), .error(error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic [3:0] v);
        coin_valid = 1'b1; coin_value = v;
        step();
        coin_valid = 1'b0; coin_value = 4'd0;
    endtask

    task automatic sel(input logic [1:0] c, input logic [2:0] n);
        sel_valid = 1'b1; sel_code = c; sel_count = n;
        step();
        sel_valid = 1'b0; sel_code = 2'd0; sel_count = 3'd0;
    endtask

    task automatic ack();
        dispense_ack = 1'b1;
        step();
        dispense_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; coin_valid = 1'b0; coin_value = 4'd0; sel_valid = 1'b0;
        sel_code = 2'd0; sel_count = 3'd0; cancel = 1'b0; dispense_ack = 1'b0;
        step(); step();
        chk("rst_credit", {4'd0, credit}, 8'd0);
        chk("rst_req", {7'd0, dispense_req}, 8'd0);
        chk("rst_change", {7'd0, change_valid}, 8'd0);
        chk("rst_reject", {7'd0, coin_reject}, 8'd0);
        chk("rst_error", {7'd0, error}, 8'd0);
        rst = 1'b0;

        // coins 5, 10, then overflow coin 1
        coin(4'd5);  chk("coin5_credit", {4'd0, credit}, 8'd5);
        chk("coin5_reject", {7'd0, coin_reject}, 8'd0);
        coin(4'd10); chk("coin10_credit", {4'd0, credit}, 8'd15);
        coin(4'd1);  chk("ovf_reject", {7'd0, coin_reject}, 8'd1);
        chk("ovf_credit", {4'd0, credit}, 8'd15);
        step();      chk("ovf_pulse_end", {7'd0, coin_reject}, 8'd0);

        // code 3 x2 = 8, ack after 3 cycles, change 7
        sel(2'd3, 3'd2);
        chk("d1_req", {7'd0, dispense_req}, 8'd1);
        chk("d1_code", {6'd0, dispense_code}, 8'd3);
        chk("d1_count", {5'd0, dispense_count}, 8'd2);
        chk("d1_credit", {4'd0, credit}, 8'd15);
        step(); chk("d2_req", {7'd0, dispense_req}, 8'd1);
        chk("d2_code", {6'd0, dispense_code}, 8'd3);
        step(); chk("d3_req", {7'd0, dispense_req}, 8'd1);
        chk("d3_count", {5'd0, dispense_count}, 8'd2);
        ack();
        chk("chg_valid", {7'd0, change_valid}, 8'd1);
        chk("chg_amount", {4'd0, change_amount}, 8'd7);
        chk("chg_req", {7'd0, dispense_req}, 8'd0);
        step();
        chk("chg_end", {7'd0, change_valid}, 8'd0);
        chk("chg_credit", {4'd0, credit}, 8'd0);
        ack();
        chk("stray_ack_req", {7'd0, dispense_req}, 8'd0);
        chk("stray_ack_chg", {7'd0, change_valid}, 8'd0);

        // insufficient credit: 3 < 6
        coin(4'd3);
        sel(2'd2, 3'd2);
        chk("poor_error", {7'd0, error}, 8'd1);
        chk("poor_credit", {4'd0, credit}, 8'd3);
        chk("poor_req", {7'd0, dispense_req}, 8'd0);
        step(); chk("poor_err_end", {7'd0, error}, 8'd0);
        cancel = 1'b1; step(); cancel = 1'b0;
        chk("poor_cancel_chg", {7'd0, change_valid}, 8'd1);
        chk("poor_cancel_amt", {4'd0, change_amount}, 8'd3);
        step(); chk("poor_cancel_credit", {4'd0, credit}, 8'd0);

        // zero-count selection refused, zero coin rejected
        coin(4'd2);
        sel(2'd0, 3'd0);
        chk("cnt0_error", {7'd0, error}, 8'd1);
        chk("cnt0_credit", {4'd0, credit}, 8'd2);
        coin(4'd0);
        chk("coin0_reject", {7'd0, coin_reject}, 8'd1);
        chk("coin0_credit", {4'd0, credit}, 8'd2);

        // cancel + sel + coin together at credit 9
        coin(4'd7); chk("c9_credit", {4'd0, credit}, 8'd9);
        cancel = 1'b1; sel_valid = 1'b1; sel_code = 2'd0; sel_count = 3'd1;
        coin_valid = 1'b1; coin_value = 4'd1;
        step();
        cancel = 1'b0; sel_valid = 1'b0; sel_count = 3'd0; coin_valid = 1'b0; coin_value = 4'd0;
        chk("prio_chg", {7'd0, change_valid}, 8'd1);
        chk("prio_amt", {4'd0, change_amount}, 8'd9);
        chk("prio_reject", {7'd0, coin_reject}, 8'd1);
        chk("prio_req", {7'd0, dispense_req}, 8'd0);
        chk("prio_error", {7'd0, error}, 8'd0);
        step(); chk("prio_credit", {4'd0, credit}, 8'd0);

        // stock exhaustion: code 0 x7 then x1
        coin(4'd7);
        sel(2'd0, 3'd7);
        chk("s7_req", {7'd0, dispense_req}, 8'd1);
        chk("s7_count", {5'd0, dispense_count}, 8'd7);
        ack();
        chk("s7_credit", {4'd0, credit}, 8'd0);
        chk("s7_req_off", {7'd0, dispense_req}, 8'd0);
        chk("s7_no_chg", {7'd0, change_valid}, 8'd0);
        coin(4'd1);
        sel(2'd0, 3'd1);
`ifdef VEND_STOCK_EN
        chk("s1_error", {7'd0, error}, 8'd1);
        chk("s1_req", {7'd0, dispense_req}, 8'd0);
        coin(4'd1);
        sel(2'd1, 3'd1);
`else
        chk("s1_error", {7'd0, error}, 8'd0);
`endif
        chk("pre_rst_req", {7'd0, dispense_req}, 8'd1);

        // reset mid-dispense forfeits credit
        rst = 1'b1; step(); rst = 1'b0;
        chk("rstd_req", {7'd0, dispense_req}, 8'd0);
        chk("rstd_credit", {4'd0, credit}, 8'd0);
        chk("rstd_chg", {7'd0, change_valid}, 8'd0);
        step(); chk("rstd_chg2", {7'd0, change_valid}, 8'd0);

        // stock refilled by reset
        coin(4'd1);
        sel(2'd0, 3'd1);
        chk("refill_req", {7'd0, dispense_req}, 8'd1);
        chk("refill_error", {7'd0, error}, 8'd0);
        ack();
        chk("refill_credit", {4'd0, credit}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
